// File: rtl/mpmc11_sync_fifo.sv
// mpmc11_sync_fifo
// Single-clock parametrised FIFO for MPMC11 ports whose client and controller
// share one clock. Supports a standard read mode with one cycle of latency and
// a first-word-fall-through (FWFT) mode.
//
// Optional feature macro: MPMC11_FIFO_PARITY_EN
//   When defined, each memory word carries one extra bit of even parity.
//   perr reports a parity error on dout, and it is qualified by v.
//   When undefined, the memory is WIDTH bits wide, perr is tied 0 and
//   perr_inj is ignored.
//
// Ports
//   clk, rst      single clock; asynchronous active-high reset
//   wr_fifo, din  write request and write data
//   rd_fifo       read request (standard mode) / pop acknowledge (FWFT mode)
//   perr_inj      flips the stored parity of the word written this cycle
//   dout, v       read data and its valid flag
//   full, empty   no write accepted / no read accepted
//   almost_full   cnt >= DEPTH-1
//   prog_full     cnt >= PROG_FULL_THRESH
//   prog_empty    cnt <= PROG_EMPTY_THRESH
//   overflow      one-cycle pulse after a write rejected while full
//   underflow     one-cycle pulse after a read rejected while empty
//   perr          parity error on dout
//   rst_busy      post-reset window; requests are ignored while it is high
//   cnt           words held; in FWFT mode this includes the output register
module mpmc11_sync_fifo #(
  parameter int WIDTH             = 32,
  parameter int DEPTH             = 32,
  parameter int FWFT              = 0,
  parameter int PROG_FULL_THRESH  = DEPTH - 5,
  parameter int PROG_EMPTY_THRESH = 5,
  parameter int RST_BUSY_CYC      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_fifo,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_fifo,
  input  logic                     perr_inj,
  output logic [WIDTH-1:0]         dout,
  output logic                     v,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     prog_full,
  output logic                     prog_empty,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     perr,
  output logic                     rst_busy,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef MPMC11_FIFO_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  localparam logic [AW:0]   L_PTR_ONE = 1;
  localparam logic [CW-1:0] L_CNT_ONE = 1;
  localparam logic [CW-1:0] L_AF      = CW'(DEPTH - 1);
  localparam logic [CW-1:0] L_PF      = CW'(PROG_FULL_THRESH);
  localparam logic [CW-1:0] L_PE      = CW'(PROG_EMPTY_THRESH);

  generate
    if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mpmc11_sync_fifo: DEPTH must be a power of two >= 16");
    end
    if (RST_BUSY_CYC < 1 || RST_BUSY_CYC > 15) begin : g_bad_busy
      $error("mpmc11_sync_fifo: RST_BUSY_CYC must be in 1..15");
    end
  endgenerate

  logic [MW-1:0]    r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_busy_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_v;
  logic             r_ovf;
  logic             r_udf;
  logic             r_perr;

  logic             w_busy;
  logic             w_full;
  logic             w_mem_empty;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;      // memory head is read and the read pointer advances
  logic             w_pop;     // client-visible read accepted (counts against cnt)
  logic             w_v_nxt;
  logic [MW-1:0]    w_head;
  logic [MW-1:0]    w_wdata;

  assign w_busy      = (r_busy_cnt != 4'd0);
  // Same address with differing wrap bits means the write pointer lapped the read pointer.
  assign w_full      = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_mem_empty = (r_wptr == r_rptr);
  assign w_wr        = wr_fifo & ~w_full & ~w_busy;
  assign w_head      = r_mem[r_rptr[AW-1:0]];

`ifdef MPMC11_FIFO_PARITY_EN
  assign w_wdata = {(^din) ^ perr_inj, din};
`else
  logic w_unused_ok;
  assign w_wdata     = din;
  assign w_unused_ok = perr_inj;
`endif

  generate
    if (FWFT != 0) begin : g_fwft
      // The output register is refilled from memory whenever it is free or being popped,
      // so consecutive pops see the next word without a bubble.
      assign w_empty = ~r_v;
      assign w_pop   = rd_fifo & r_v & ~w_busy;
      assign w_rd    = ~w_mem_empty & (~r_v | w_pop);
      assign w_v_nxt = w_rd | (r_v & ~w_pop);
    end else begin : g_std
      assign w_empty = w_mem_empty;
      assign w_pop   = rd_fifo & ~w_mem_empty & ~w_busy;
      assign w_rd    = w_pop;
      assign w_v_nxt = w_pop;
    end
  endgenerate

  // Storage: contents are never reset, pointer reset discards them.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= w_wdata;
    end
  end

  // Control, counters, output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_busy_cnt <= 4'(RST_BUSY_CYC);
      r_dout     <= '0;
      r_v        <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      if (w_busy) begin
        r_busy_cnt <= r_busy_cnt - 4'd1;
      end
      if (w_wr) begin
        r_wptr <= r_wptr + L_PTR_ONE;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + L_PTR_ONE;
        r_dout <= w_head[WIDTH-1:0];
      end
      if (w_wr && !w_pop) begin
        r_cnt <= r_cnt + L_CNT_ONE;
      end else if (!w_wr && w_pop) begin
        r_cnt <= r_cnt - L_CNT_ONE;
      end
      r_v    <= w_v_nxt;
      // A held FWFT word keeps its error flag; a freshly loaded word gets a new one.
      r_perr <= w_rd ? (^w_head) : (w_v_nxt & r_perr);
      r_ovf  <= wr_fifo & w_full & ~w_busy;
      r_udf  <= rd_fifo & w_empty & ~w_busy;
    end
  end

  assign dout        = r_dout;
  assign v           = r_v;
  assign full        = w_full;
  assign empty       = w_empty;
  assign almost_full = (r_cnt >= L_AF);
  assign prog_full   = (r_cnt >= L_PF);
  assign prog_empty  = (r_cnt <= L_PE);
  assign overflow    = r_ovf;
  assign underflow   = r_udf;
  assign rst_busy    = w_busy;
  assign cnt         = r_cnt;
`ifdef MPMC11_FIFO_PARITY_EN
  assign perr        = r_perr;
`else
  assign perr        = 1'b0;
`endif

endmodule

// File: tb/tb_mpmc11_sync_fifo.sv
module tb_mpmc11_sync_fifo;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int RB = 4;
`ifdef MPMC11_FIFO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, wr_fifo, rd_fifo, perr_inj;
  logic [W-1:0] din;

  logic [W-1:0] s_dout, f_dout;
  logic s_v, s_full, s_empty, s_af, s_pf, s_pe, s_ovf, s_udf, s_perr, s_busy;
  logic f_v, f_full, f_empty, f_af, f_pf, f_pe, f_ovf, f_udf, f_perr, f_busy;
  logic [4:0] s_cnt, f_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mpmc11_sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(0), .RST_BUSY_CYC(RB)) u_std (
    .clk(clk), .rst(rst), .wr_fifo(wr_fifo), .din(din), .rd_fifo(rd_fifo), .perr_inj(perr_inj),
    .dout(s_dout), .v(s_v), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .prog_full(s_pf), .prog_empty(s_pe), .overflow(s_ovf), .underflow(s_udf),
    .perr(s_perr), .rst_busy(s_busy), .cnt(s_cnt));

  mpmc11_sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(1), .RST_BUSY_CYC(RB)) u_fwft (
    .clk(clk), .rst(rst), .wr_fifo(wr_fifo), .din(din), .rd_fifo(rd_fifo), .perr_inj(perr_inj),
    .dout(f_dout), .v(f_v), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .prog_full(f_pf), .prog_empty(f_pe), .overflow(f_ovf), .underflow(f_udf),
    .perr(f_perr), .rst_busy(f_busy), .cnt(f_cnt));

  // Reference model: queues of {parity_bad, data}.
  int           m_busy;
  logic [W:0]   q_s[$];
  logic [W:0]   q_f[$];
  logic [W-1:0] ms_dout, mf_dout;
  bit           ms_v, ms_perr, ms_ovf, ms_udf;
  bit           mf_has, mf_perr, mf_ovf, mf_udf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_s.delete();
    q_f.delete();
    m_busy  = RB;
    ms_dout = '0; ms_v = 0; ms_perr = 0; ms_ovf = 0; ms_udf = 0;
    mf_dout = '0; mf_has = 0; mf_perr = 0; mf_ovf = 0; mf_udf = 0;
  endtask

  task automatic model_edge();
    bit busy, pop, had;
    int sz, szf;
    logic [W:0] e;
    busy = (m_busy > 0);
    // Standard mode: a read returns the oldest word next cycle as a one-cycle v pulse.
    sz     = q_s.size();
    ms_ovf = wr_fifo && sz == D && !busy;
    ms_udf = rd_fifo && sz == 0 && !busy;
    ms_v   = 0;
    ms_perr = 0;
    if (rd_fifo && sz > 0 && !busy) begin
      e = q_s.pop_front();
      ms_dout = e[W-1:0];
      ms_v    = 1;
      ms_perr = e[W] & PAR;
    end
    if (wr_fifo && sz < D && !busy) q_s.push_back({perr_inj, din});
    // FWFT mode: q_f is what sits in memory, mf_has is the word shown on dout.
    szf    = q_f.size();
    had    = mf_has;
    mf_ovf = wr_fifo && szf == D && !busy;
    mf_udf = rd_fifo && !had && !busy;
    pop    = rd_fifo && had && !busy;
    if ((!had || pop) && szf > 0) begin
      e = q_f.pop_front();
      mf_dout = e[W-1:0];
      mf_perr = e[W] & PAR;
      mf_has  = 1;
    end else if (pop) begin
      mf_has  = 0;
      mf_perr = 0;
    end
    if (wr_fifo && szf < D && !busy) q_f.push_back({perr_inj, din});
    if (m_busy > 0) m_busy--;
  endtask

  task automatic compare();
    int cs, cf;
    cs = q_s.size();
    cf = q_f.size() + int'(mf_has);
    chk("std_dout", s_dout, ms_dout);
    chk("std_v", s_v, ms_v);
    chk("std_full", s_full, cs == D);
    chk("std_empty", s_empty, cs == 0);
    chk("std_af", s_af, cs >= D - 1);
    chk("std_pf", s_pf, cs >= D - 5);
    chk("std_pe", s_pe, cs <= 5);
    chk("std_ovf", s_ovf, ms_ovf);
    chk("std_udf", s_udf, ms_udf);
    chk("std_perr", s_perr, ms_perr);
    chk("std_busy", s_busy, m_busy > 0);
    chk("std_cnt", s_cnt, cs);
    chk("fw_dout", f_dout, mf_dout);
    chk("fw_v", f_v, mf_has);
    chk("fw_full", f_full, q_f.size() == D);
    chk("fw_empty", f_empty, !mf_has);
    chk("fw_af", f_af, cf >= D - 1);
    chk("fw_pf", f_pf, cf >= D - 5);
    chk("fw_pe", f_pe, cf <= 5);
    chk("fw_ovf", f_ovf, mf_ovf);
    chk("fw_udf", f_udf, mf_udf);
    chk("fw_perr", f_perr, mf_perr);
    chk("fw_busy", f_busy, m_busy > 0);
    chk("fw_cnt", f_cnt, cf);
  endtask

  // One clock: model advances with the pre-edge inputs, outputs are compared on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    wr_fifo = 0; rd_fifo = 0; perr_inj = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    wr_fifo = 0; rd_fifo = 0; perr_inj = 0;
    #2 rst = 1;
    #1 model_reset();
    chk("rst_std_cnt", s_cnt, 0);
    chk("rst_std_dout", s_dout, 0);
    chk("rst_std_empty", s_empty, 1);
    chk("rst_std_busy", s_busy, 1);
    chk("rst_fw_v", f_v, 0);
    chk("rst_fw_cnt", f_cnt, 0);
    chk("rst_fw_full", f_full, 0);
    chk("rst_fw_pe", f_pe, 1);
    compare();
    step();
    rst = 0;
    idle(RB);
  endtask

  initial begin
    rst = 1; wr_fifo = 0; rd_fifo = 0; perr_inj = 0; din = '0;
    model_reset();
    @(negedge clk);
    chk("init_empty", s_empty, 1);
    chk("init_pe", s_pe, 1);
    chk("init_busy", s_busy, 1);
    chk("init_fw_v", f_v, 0);
    compare();
    step();
    rst = 0;

    // Writes during the busy window are ignored.
    wr_fifo = 1; din = 8'h77;
    for (int k = 1; k <= RB; k++) begin
      step();
      chk("busy_window", s_busy, (k < RB) ? 1 : 0);
      chk("busy_cnt", s_cnt, 0);
      chk("busy_ovf", s_ovf, 0);
    end
    wr_fifo = 0;
    step();

    // Fill the standard FIFO.
    for (int i = 0; i < D; i++) begin
      wr_fifo = 1; din = 8'(i);
      step();
      chk("fill_af", s_af, (i + 1 >= D - 1) ? 1 : 0);
      chk("fill_full", s_full, (i == D - 1) ? 1 : 0);
      chk("fill_cnt", s_cnt, i + 1);
    end
    chk("model_full_size", q_s.size(), 16);
    din = 8'hFF;
    step();
    chk("ovf_pulse", s_ovf, 1);
    chk("ovf_cnt", s_cnt, 16);
    wr_fifo = 0;
    step();
    chk("ovf_clear", s_ovf, 0);

    // Drain; one extra read for the underflow (the FWFT instance holds 17 words).
    for (int i = 0; i < D; i++) begin
      rd_fifo = 1;
      step();
      chk("drain_dout", s_dout, i);
      chk("drain_v", s_v, 1);
    end
    step();
    chk("udf_pulse", s_udf, 1);
    chk("udf_v", s_v, 0);
    chk("udf_empty", s_empty, 1);
    chk("udf_cnt", s_cnt, 0);
    chk("udf_dout_hold", s_dout, 8'h0F);
    rd_fifo = 0;
    step();
    chk("udf_clear", s_udf, 0);
    idle(2);

    // Wrap: 8 words in, then 40 simultaneous read+write cycles.
    for (int i = 0; i < 8; i++) begin
      wr_fifo = 1; din = 8'(8'h20 + i);
      step();
    end
    for (int k = 0; k < 40; k++) begin
      wr_fifo = 1; rd_fifo = 1; din = 8'(8'h40 + k);
      step();
      chk("wrap_cnt", s_cnt, 8);
      chk("wrap_dout", s_dout, (k < 8) ? (32'h20 + k) : (32'h40 + k - 8));
    end
    rd_fifo = 0;
    for (int i = 0; i < 8; i++) begin
      wr_fifo = 1; din = 8'(8'h80 + i);
      step();
    end
    chk("wrap_full", s_full, 1);
    wr_fifo = 1; rd_fifo = 1; din = 8'hEE;
    step();
    chk("rdwr_full_ovf", s_ovf, 1);
    chk("rdwr_full_cnt", s_cnt, 15);
    chk("rdwr_full_v", s_v, 1);
    wr_fifo = 0;
    for (int i = 0; i < 20; i++) step();
    idle(1);

    // FWFT: first word falls through, then back-to-back pops.
    async_reset();
    wr_fifo = 1; din = 8'hA5;
    step();
    chk("fwft_not_yet", f_v, 0);
    wr_fifo = 0;
    step();
    chk("fwft_v", f_v, 1);
    chk("fwft_dout", f_dout, 8'hA5);
    chk("fwft_empty", f_empty, 0);
    for (int i = 0; i < 3; i++) begin
      wr_fifo = 1; din = 8'(8'hB0 + i);
      step();
    end
    wr_fifo = 0;
    step();
    for (int k = 0; k < 4; k++) begin
      rd_fifo = 1;
      step();
      chk("fwft_pop_v", f_v, (k < 3) ? 1 : 0);
      if (k < 3) chk("fwft_pop_dout", f_dout, 32'hB0 + k);
    end
    chk("fwft_end_empty", f_empty, 1);
    rd_fifo = 0;
    step();

`ifdef MPMC11_FIFO_PARITY_EN
    for (int i = 0; i < 3; i++) begin
      wr_fifo = 1; din = 8'(8'h5A + i); perr_inj = (i == 1);
      step();
    end
    wr_fifo = 0; perr_inj = 0;
    for (int i = 0; i < 3; i++) begin
      rd_fifo = 1;
      step();
      chk("par_std_perr", s_perr, (i == 1) ? 1 : 0);
    end
    idle(3);
`endif

    // Reset in the middle of traffic.
    for (int i = 0; i < 5; i++) begin
      wr_fifo = 1; din = 8'($urandom);
      step();
    end
    async_reset();

    // Randomized traffic with shifting write/read bias.
    for (int c = 0; c < 3000; c++) begin
      int pw, pr;
      pw = 20 + 30 * ((c / 200) % 3);
      pr = 80 - 30 * ((c / 300) % 3);
      wr_fifo  = ($urandom_range(99) < pw);
      rd_fifo  = ($urandom_range(99) < pr);
      din      = 8'($urandom);
      perr_inj = ($urandom_range(7) == 0);
      if (c == 1500) async_reset();
      else step();
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
